// File: rtl/mux_nx1_rr.sv
// Purpose: N-channel registered mux with per-channel valid/ready, fixed-select or round-robin grant.
// Latency: one cycle from input acceptance to out_valid/out_data/out_ch.
// Backpressure: output stage reloads when empty or consumed; while it is stalled every in_ready is low.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   mode                 : 0 = fixed select by sel, 1 = round-robin over in_valid
//   sel                  : channel chosen in fixed mode (values >= N_CH never grant)
//   in_data/in_valid     : packed channel data (channel k at [k*WIDTH +: WIDTH]) and requests
//   in_ready             : per-channel accept, one-hot or zero
//   out_data/out_ch      : registered winning data and the channel index that supplied it
//   out_valid/out_ready  : downstream handshake
module mux_nx1_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] ch_data [N_CH];
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
    end

    assign load_en = !out_valid || out_ready;

    // Grant selection. Round-robin walks (last+1 .. last+N_CH) with an explicit
    // wrap so non-power-of-2 channel counts never index past the last channel.
    always_comb begin : p_grant
        int               idx;
        logic [SEL_W-1:0] idx_s;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        idx_s     = '0;
        if (!mode) begin
            if (int'(sel) < N_CH) begin
                grant_vld = in_valid[sel];
                grant     = sel;
            end
        end else begin
            for (int i = 1; i <= N_CH; i++) begin
                idx = int'(last) + i;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                idx_s = SEL_W'(idx);
                if (!grant_vld && in_valid[idx_s]) begin
                    grant_vld = 1'b1;
                    grant     = idx_s;
                end
            end
        end
    end

    // Gated by rst_n so no source sees an accept while the block is held in reset.
    assign xfer = rst_n && grant_vld && load_en;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            // Start one behind channel 0 so the first round-robin search begins there.
            last      <= SEL_W'(N_CH - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant];
                out_ch    <= grant;
                last      <= grant;
            end else begin
                // Data and index keep their stale values; only valid drops.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes. It has two modes: fixed select, driven by an external `sel`, and round-robin arbitration across requesting channels. A single output register stage carries the chosen channel's data and index to a downstream valid/ready consumer. It is the next-generation replacement for the team's combinational 4x1 mux wherever sources are streaming and can stall.

## Interface
- `N_CH`, default 4: number of input channels; legal range is 2 or more.
- `WIDTH`, default 8: data width per channel.
- `SEL_W`, default `$clog2(N_CH)`: width of the select and channel index; derived, not overridden.

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset; asynchronous assert, active-low.
- `mode`  in  1: 0 = fixed select, 1 = round-robin.
- `sel`  in  SEL_W: channel selected when `mode`=0.
- `in_data`  in  N_CH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  N_CH: per-channel request.
- `in_ready`  out  N_CH: per-channel accept; one-hot or zero.
- `out_data`  out  WIDTH: registered selected data.
- `out_ch`  out  SEL_W: index of the channel that supplied `out_data`.
- `out_valid`  out  1: output register holds valid data.
- `out_ready`  in  1: downstream accept.

## Operation
- **Load enable:** `load_en = !out_valid || out_ready`. This gives a full-throughput single stage.
- **Grant, fixed mode (`mode`=0):** grant g = `sel` if `sel` < N_CH and `in_valid[sel]`; otherwise no grant. Other channels' valids are ignored.
- **Grant, round-robin (`mode`=1):**
  - Search `in_valid` starting at (`last`+1) mod N_CH and wrapping.
  - g is the first valid channel found; if none are valid, there is no grant.
- **`in_ready`:** `in_ready[g] = load_en` when a grant exists; all other bits are 0. The grant and `in_ready` are combinational from current inputs and state.
- **Transfer:** a transfer occurs when `in_valid[g] && in_ready[g]`. On that edge:
  - `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`, `last <= g`.
  - `last` updates in both modes, so switching to round-robin continues from the last served channel.
- **No grant:** if `load_en` is high and there is no grant, `out_valid <= 0`. `out_data` and `out_ch` hold their previous values, which are don't-care.
- **Stall:** `out_valid && !out_ready` means `out_data`, `out_ch`, `out_valid` and `last` all hold, and all `in_ready` bits are 0.
- **Mode or `sel` change:** takes effect on the next grant evaluation. Data already in the output register is unaffected.
- **Arithmetic:** the wrap uses a modulo-N_CH increment, so it is correct for non-power-of-2 N_CH. `sel` values ≥ N_CH never grant.

## Timing
- **Reset (async, `rst_n`=0):**
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `last`=N_CH-1, so the first round-robin search starts at channel 0.
  - `in_ready`=0 while in reset.
  - Reset mid-transfer discards the registered word without any handshake.
- **Latency:** an input accepted at edge t appears on `out_data`/`out_valid` immediately after edge t, i.e. one cycle.
- **Throughput:** one word per cycle when `out_ready` is held at 1.
- **Simultaneous events:** when the output is consumed and a new word is accepted on the same edge, the register reloads with no bubble.
- **Round-robin fairness:** with all channels continuously valid and `out_ready`=1, grants cycle 0,1,…,N_CH-1,0. No channel waits more than N_CH-1 grants.

## Test plan
- **Reset and idle:** hold `rst_n`=0, then release with all `in_valid`=0.
  - Required: `out_valid`=0, `out_data`=0, `out_ch`=0, `in_ready`=0, held for 5 cycles.
- **Fixed select:** `mode`=0, N_CH=4, WIDTH=8, `in_data`={8'h33,8'h22,8'h11,8'h00}, all valid, `sel` stepped 0→1→2→3, `out_ready`=1.
  - Required: `out_data` = 00, 11, 22, 33 on successive cycles, with `out_ch` = 0–3 one cycle after each `sel`.
  - Then `sel`=2 with `in_valid[2]`=0: no grant, and `out_valid` drops to 0.
- **Round-robin fairness:** `mode`=1, all valid, `out_ready`=1 for 8 cycles.
  - Required: `out_ch` sequence is 0,1,2,3,0,1,2,3.
  - Then `in_valid`=4'b1010: `out_ch` alternates 1,3,1,3 (wrap skips invalid channels).
- **Backpressure:** `mode`=1, all valid, `out_ready`=0 for 3 cycles after the first load.
  - Required: `out_valid`=1, and `out_data`/`out_ch` stay at channel 0 with no change.
  - Required: `in_ready`=0 throughout.
  - When `out_ready` is raised, the next output is channel 1; no channel is skipped or duplicated.
- **Mode switch:** serve channel 2 in fixed mode, then set `mode`=1 with all valid.
  - Required: the next grants are 3, then 0.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously between edges while `out_valid`=1 and a stall is in progress.
  - Required: `out_valid` drops immediately, without waiting for a clock edge.
  - After release with all valid, the first `out_ch` is 0.
